// File: rtl/proc_pkt_gen_pkg.sv
// Shared global-buffer parameters and the burst-engine state type.
package proc_pkt_gen_pkg;
  localparam int DEF_BANK_DATA_WIDTH = 64;
  localparam int DEF_GLB_ADDR_WIDTH  = 22;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;
endpackage

// File: rtl/proc_rd_fifo.sv
// Read-response buffer: synchronous push/pop, both allowed in the same cycle.
module proc_rd_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/proc_pkt_gen.sv
// Burst engine turning write/read commands into single-beat GLB processor packets,
// with credit-limited read issue so responses always fit the return buffer.
module proc_pkt_gen
  import proc_pkt_gen_pkg::*;
#(
  parameter int BANK_DATA_WIDTH = DEF_BANK_DATA_WIDTH,
  parameter int GLB_ADDR_WIDTH  = DEF_GLB_ADDR_WIDTH,
  parameter int RD_FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [GLB_ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [15:0]                  cmd_len,
  input  logic                         wdata_valid,
  output logic                         wdata_ready,
  input  logic [BANK_DATA_WIDTH-1:0]   wdata,
  input  logic [BANK_DATA_WIDTH/8-1:0] wdata_strb,
  output logic                         rdata_valid,
  input  logic                         rdata_ready,
  output logic [BANK_DATA_WIDTH-1:0]   rdata,
  output logic                         wr_en,
  output logic [BANK_DATA_WIDTH/8-1:0] wr_strb,
  output logic [GLB_ADDR_WIDTH-1:0]    wr_addr,
  output logic [BANK_DATA_WIDTH-1:0]   wr_data,
  output logic                         rd_en,
  output logic [GLB_ADDR_WIDTH-1:0]    rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0]   rd_data,
  input  logic                         rd_data_valid,
  output logic                         done,
  output logic                         err
);
  localparam int STRB_W = BANK_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(RD_FIFO_DEPTH) + 1;

  state_e                      state_q, state_d;
  logic [GLB_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]                 len_q, len_d;
  logic [CNT_W-1:0]            outst_q, outst_d;
  logic                        wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [STRB_W-1:0]           wr_strb_q, wr_strb_d;
  logic [GLB_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [BANK_DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                        done_q, done_d, err_q, err_d;

  logic                        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]            fifo_count;
  logic                        resp_ok, room, issue, last_pop;
  logic [GLB_ADDR_WIDTH-1:0]   addr_step;

  proc_rd_fifo #(.W(BANK_DATA_WIDTH), .DEPTH(RD_FIFO_DEPTH)) u_rd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (rd_data),
    .pop   (fifo_pop),
    .dout  (rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // A response is only legitimate if a read is still in flight; anything else is stray.
  assign resp_ok     = rd_data_valid && (outst_q != '0);
  assign fifo_push   = resp_ok && !fifo_full;
  assign rdata_valid = !fifo_empty;
  assign fifo_pop    = rdata_valid && rdata_ready;
  assign room        = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CNT_W+1)'(RD_FIFO_DEPTH);
  assign last_pop    = (state_q == DRAIN) && fifo_pop && (outst_q == '0) &&
                       (fifo_count == CNT_W'(1));
  assign addr_step   = addr_q + GLB_ADDR_WIDTH'(STRB_W);

  assign cmd_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign wr_en       = wr_en_q;
  assign wr_strb     = wr_strb_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign done        = done_q || last_pop;
  assign err         = err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_strb_d = wr_strb_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    err_d     = err_q || (rd_data_valid && (outst_q == '0));
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr & ~GLB_ADDR_WIDTH'(STRB_W - 1);
          len_d  = cmd_len;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = wdata;
          wr_strb_d = wdata_strb;
          addr_d    = addr_step;
          len_d     = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (room) begin
          issue     = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
          addr_d    = addr_step;
          len_d     = len_q - 16'd1;
          if (len_q == 16'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    unique case ({issue, resp_ok})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      outst_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_strb_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      outst_q   <= outst_d;
      wr_en_q   <= wr_en_d;
      wr_strb_q <= wr_strb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
endmodule
